digi_ota_scan_ctrl: RTL and testbench
=====================================

Name: digi_ota_scan_ctrl

Overview:
- Sequencer that time-shares one digital OTA/comparator cell between NCH differential input pairs.
- Scans the enabled channels in ascending index order. For each channel it drives the pair onto the OTA inputs, waits a settle window, majority-votes NSAMP samples of the OTA output, and stores one result bit per channel.
- Sits between the user-pin input mux and the OTA instance inside the top wrapper.

Parameters:
- NCH, 4, number of input channel pairs (2..8).
- SETTLE, 3, cycles OTA output is ignored after a channel switch (≥1).
- NSAMP, 5, samples per channel; must be odd, ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable; low freezes all state, counters and outputs.
- start  input  1  request a scan; sampled only in IDLE.
- ch_mask  input  NCH  channel enable mask; latched when start is accepted.
- vip_ch  input  NCH  positive input per channel.
- vin_ch  input  NCH  negative input per channel.
- ota_vip  output  1  registered drive to OTA positive input.
- ota_vin  output  1  registered drive to OTA negative input.
- ota_out  input  1  OTA output.
- result  output  NCH  per-channel decision bits.
- res_valid  output  1  one-cycle pulse when a scan completes.
- busy  output  1  high in every state except IDLE.
- cur_ch  output  clog2(NCH)  index of the channel being measured; 0 in IDLE.

Behaviour:
- Reset values: ota_vip=0, ota_vin=0, result=0, res_valid=0, busy=0, cur_ch=0, state=IDLE, all counters 0.
- States: IDLE, SELECT, SETTLE, SAMPLE, STORE, DONE. When ena=0, nothing changes.
- IDLE:
  - start=1 with ch_mask≠0 → latch mask, clear result to 0, go to SELECT.
  - start=1 with ch_mask=0 → ignored; stay in IDLE.
  - ota_vip and ota_vin are held at 0.
- SELECT (1 cycle):
  - cur_ch ← lowest set bit of the remaining mask.
  - ota_vip ← vip_ch[cur_ch], ota_vin ← vin_ch[cur_ch]; these are re-registered every cycle until STORE.
  - Clear that bit from the remaining mask; load the settle counter; go to SETTLE.
- SETTLE (SETTLE cycles): ota_out is ignored; then go to SAMPLE with the ones counter = 0.
- SAMPLE (NSAMP cycles): at each edge, ones += ota_out; then go to STORE.
- STORE (1 cycle):
  - result[cur_ch] ← (ones > NSAMP/2).
  - Remaining mask ≠0 → SELECT; otherwise → DONE.
- DONE (1 cycle): res_valid=1, then go to IDLE. result holds until the next accepted start.
- Latency: if start is accepted at edge k, DONE is entered at edge k + n·(2+SETTLE+NSAMP), where n = popcount(mask). With defaults that is 10 cycles per channel.
- Masked-off channels read 0 in result.
- start while busy is ignored. ch_mask changes mid-scan have no effect.
- Async reset mid-scan returns immediately to the reset values; the partial scan is discarded.
- The ones counter is clog2(NSAMP+1) bits and never wraps.

Optional Feature:
- Macro: DIGI_OTA_UNANIMOUS_EN.
- Defined: STORE writes result[cur_ch] only when all NSAMP samples agree (ones==0 or ones==NSAMP); otherwise the bit keeps its previous value. result is not cleared at start; the bits of masked-off channels also keep their previous values.
- Undefined: majority vote as above.

Test Plan:
- Reset, then NCH=4 defaults; start with ch_mask=4'b0001, vip_ch[0]=1, vin_ch[0]=0, ota_out tied to 1 → ota_vip=1 from edge k+1; res_valid pulses at edge k+10; result=4'b0001; busy high edges k..k+10.
- ch_mask=4'b1010, ota_out=1 for channel 1 and 0 for channel 3 → cur_ch sequence 1 then 3; res_valid at k+20; result=4'b0010.
- ch_mask=4'b0001, ota_out samples 1,0,1,0,1 → result[0]=1; samples 0,1,0,1,0 → result[0]=0. With DIGI_OTA_UNANIMOUS_EN both cases hold the prior value.
- start pulsed again during a scan and ch_mask changed mid-scan → ignored; completion timing and result unchanged. start with ch_mask=0 → busy stays 0.
- ena held low for 7 cycles during SAMPLE → state, counters and cur_ch frozen; res_valid delayed by exactly 7 cycles.
- rst_n asserted during SETTLE of channel 2 → all outputs at reset values immediately; the next start behaves as a clean scan.

Source files
------------

// File: rtl/digi_ota_scan_ctrl.sv
// Sequencer that time-shares one digital OTA between NCH differential pairs.
// Define DIGI_OTA_UNANIMOUS_EN to store a bit only when all samples agree.
module digi_ota_scan_ctrl #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned NSAMP  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic [NCH-1:0]           ch_mask,
  input  logic [NCH-1:0]           vip_ch,
  input  logic [NCH-1:0]           vin_ch,
  output logic                     ota_vip,
  output logic                     ota_vin,
  input  logic                     ota_out,
  output logic [NCH-1:0]           result,
  output logic                     res_valid,
  output logic                     busy,
  output logic [$clog2(NCH)-1:0]   cur_ch
);

  localparam int unsigned ChW = $clog2(NCH);
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned OnesW = $clog2(NSAMP + 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);
  localparam logic [OnesW-1:0] SampLast = OnesW'(NSAMP - 1);
`ifdef DIGI_OTA_UNANIMOUS_EN
  localparam logic [OnesW-1:0] SampAll = OnesW'(NSAMP);
`else
  localparam logic [OnesW-1:0] SampHalf = OnesW'(NSAMP / 2);
`endif

  typedef enum logic [2:0] {
    StIdle, StSelect, StSettle, StSample, StStore, StDone
  } state_e;

  state_e             state_q;
  logic [NCH-1:0]     mask_q;
  logic [SetW-1:0]    settle_q;
  logic [OnesW-1:0]   samp_q;
  logic [OnesW-1:0]   ones_q;
  logic [ChW-1:0]     next_ch;

  // Lowest remaining channel: scan downward so the lowest set bit wins.
  always_comb begin
    next_ch = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask_q[i]) next_ch = ChW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      settle_q  <= '0;
      samp_q    <= '0;
      ones_q    <= '0;
      ota_vip   <= 1'b0;
      ota_vin   <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      cur_ch    <= '0;
    end else if (ena) begin
      res_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ota_vip <= 1'b0;
          ota_vin <= 1'b0;
          cur_ch  <= '0;
          if (start && (|ch_mask)) begin
            mask_q  <= ch_mask;
`ifndef DIGI_OTA_UNANIMOUS_EN
            result  <= '0;
`endif
            busy    <= 1'b1;
            state_q <= StSelect;
          end
        end
        StSelect: begin
          cur_ch          <= next_ch;
          ota_vip         <= vip_ch[next_ch];
          ota_vin         <= vin_ch[next_ch];
          mask_q[next_ch] <= 1'b0;
          settle_q        <= SettleLast;
          state_q         <= StSettle;
        end
        StSettle: begin
          ota_vip <= vip_ch[cur_ch];
          ota_vin <= vin_ch[cur_ch];
          if (settle_q == '0) begin
            ones_q  <= '0;
            samp_q  <= '0;
            state_q <= StSample;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StSample: begin
          ota_vip <= vip_ch[cur_ch];
          ota_vin <= vin_ch[cur_ch];
          ones_q  <= ones_q + OnesW'(ota_out);
          if (samp_q == SampLast) begin
            state_q <= StStore;
          end else begin
            samp_q <= samp_q + 1'b1;
          end
        end
        StStore: begin
`ifdef DIGI_OTA_UNANIMOUS_EN
          // Split votes leave the previous decision untouched.
          if (ones_q == '0) begin
            result[cur_ch] <= 1'b0;
          end else if (ones_q == SampAll) begin
            result[cur_ch] <= 1'b1;
          end
`else
          result[cur_ch] <= (ones_q > SampHalf);
`endif
          if (|mask_q) begin
            state_q <= StSelect;
          end else begin
            res_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          cur_ch  <= '0;
          ota_vip <= 1'b0;
          ota_vin <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_digi_ota_scan_ctrl.sv
// Randomized bench for digi_ota_scan_ctrl against a timing/vote reference model.
module tb_digi_ota_scan_ctrl;

  localparam int unsigned NCH    = 4;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned NSAMP  = 5;
  localparam int P    = 2 + SETTLE + NSAMP;
  localparam int MaxT = NCH * P + 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic           start;
  logic [NCH-1:0] ch_mask;
  logic [NCH-1:0] vip_ch;
  logic [NCH-1:0] vin_ch;
  logic           ota_vip;
  logic           ota_vin;
  logic           ota_out;
  logic [NCH-1:0] result;
  logic           res_valid;
  logic           busy;
  logic [1:0]     cur_ch;

  int n_checks = 0;
  int n_errors = 0;
  logic [NCH-1:0] model_res;

  always #5 clk = ~clk;

  digi_ota_scan_ctrl #(
    .NCH    (NCH),
    .SETTLE (SETTLE),
    .NSAMP  (NSAMP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .ch_mask   (ch_mask),
    .vip_ch    (vip_ch),
    .vin_ch    (vin_ch),
    .ota_vip   (ota_vip),
    .ota_vin   (ota_vin),
    .ota_out   (ota_out),
    .result    (result),
    .res_valid (res_valid),
    .busy      (busy),
    .cur_ch    (cur_ch)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ota_vip"}, int'(ota_vip), 0);
    check_eq({tag, "_ota_vin"}, int'(ota_vin), 0);
    check_eq({tag, "_result"}, int'(result), 0);
    check_eq({tag, "_res_valid"}, int'(res_valid), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_cur_ch"}, int'(cur_ch), 0);
  endtask

  // mode 0: random ota_out; 1: fixed level per channel (fixv); 2: sample pattern pat[s].
  task automatic run_scan(input logic [NCH-1:0] mask, input logic [NCH-1:0] vp,
                          input logic [NCH-1:0] vn, input int mode,
                          input logic [NCH-1:0] fixv, input logic [NSAMP-1:0] pat,
                          input int gap_at, input bit perturb);
    int chl[$];
    int n, t, edges, gap_left, rv_edge, budget, j, s, ones;
    bit gap_done;
    bit samp [0:MaxT];
    logic v;
    logic [NCH-1:0] expv;
    for (int c = 0; c < int'(NCH); c++) if (mask[c]) chl.push_back(c);
    n = chl.size();
    vip_ch  = vp;
    vin_ch  = vn;
    ena     = 1'b1;
    start   = 1'b1;
    ch_mask = mask;
    ota_out = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    t = 0; edges = 0; gap_left = 0; gap_done = 1'b0; rv_edge = -1; budget = n * P + 30;
    check_eq("accept_busy", int'(busy), 1);
    check_eq("accept_ota_vip", int'(ota_vip), 0);
    while (t <= n * P && budget > 0) begin
      if (!gap_done && gap_at > 0 && t == gap_at) begin
        gap_left = 7;
        gap_done = 1'b1;
      end
      if (gap_left > 0) begin
        ena = 1'b0;
        gap_left--;
      end else begin
        ena = 1'b1;
      end
      j = t / P;
      s = (t + 1) - j * P - (2 + int'(SETTLE));
      v = 1'($urandom_range(0, 1));
      if (j < n) begin
        if (mode == 1) v = fixv[chl[j]];
        else if (mode == 2 && s >= 0 && s < int'(NSAMP)) v = pat[s];
      end
      ota_out = v;
      if (perturb && t < n * P) begin
        start   = 1'($urandom_range(0, 1));
        ch_mask = NCH'($urandom);
      end else begin
        start   = 1'b0;
        ch_mask = mask;
      end
      @(posedge clk); #1;
      edges++;
      budget--;
      if (ena) begin
        t++;
        samp[t] = v;
      end
      check_eq("busy", int'(busy), int'(t <= n * P));
      check_eq("res_valid", int'(res_valid), int'(t == n * P));
      if (res_valid && rv_edge < 0) rv_edge = edges;
      if (t >= 1 && t <= n * P) begin
        j = (t - 1) / P;
        check_eq("cur_ch", int'(cur_ch), chl[j]);
        check_eq("ota_vip", int'(ota_vip), int'(vp[chl[j]]));
        check_eq("ota_vin", int'(ota_vin), int'(vn[chl[j]]));
      end else if (t > n * P) begin
        check_eq("idle_cur_ch", int'(cur_ch), 0);
        check_eq("idle_ota_vip", int'(ota_vip), 0);
      end
    end
    start   = 1'b0;
    ch_mask = mask;
    ena     = 1'b1;
    check_eq("scan_timeout", int'(budget > 0), 1);
    check_eq("rv_edge", rv_edge, n * P + (gap_done ? 7 : 0));
`ifdef DIGI_OTA_UNANIMOUS_EN
    expv = model_res;
`else
    expv = '0;
`endif
    for (int k = 0; k < n; k++) begin
      ones = 0;
      for (int q = 0; q < int'(NSAMP); q++) ones += int'(samp[k * P + 2 + int'(SETTLE) + q]);
`ifdef DIGI_OTA_UNANIMOUS_EN
      if (ones == 0) expv[chl[k]] = 1'b0;
      else if (ones == int'(NSAMP)) expv[chl[k]] = 1'b1;
`else
      expv[chl[k]] = (ones > int'(NSAMP) / 2);
`endif
    end
    check_eq("result", int'(result), int'(expv));
    model_res = expv;
  endtask

  task automatic idle_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      ota_out = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("hold_result", int'(result), int'(model_res));
      check_eq("hold_busy", int'(busy), 0);
    end
  endtask

  task automatic reset_mid_scan();
    vip_ch  = 4'b1111;
    vin_ch  = 4'b0000;
    ena     = 1'b1;
    start   = 1'b1;
    ch_mask = 4'b0111;
    ota_out = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 2 * P + 3; t++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_rst_cur_ch", int'(cur_ch), 2);
    check_eq("pre_rst_result", int'(result[1:0]), 3);
    check_eq("pre_rst_ota_vip", int'(ota_vip), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #2 rst_n = 1'b1;
    model_res = '0;
  endtask

  initial begin
    logic [NCH-1:0] m;
    int gap;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; ch_mask = '0;
    vip_ch = '0; vin_ch = '0; ota_out = 1'b0; model_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(4'b0001, 4'b0001, 4'b0000, 1, 4'b1111, '0, 0, 1'b0);
    idle_hold(2);
    run_scan(4'b1010, NCH'($urandom), NCH'($urandom), 1, 4'b0010, '0, 0, 1'b0);
    run_scan(4'b0001, 4'b0001, 4'b0000, 2, '0, 5'b10101, 0, 1'b0);
    run_scan(4'b0001, 4'b0001, 4'b0000, 2, '0, 5'b01010, 0, 1'b0);
    run_scan(4'b1011, NCH'($urandom), NCH'($urandom), 0, '0, '0, 0, 1'b1);

    start = 1'b1; ch_mask = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("zero_mask_busy", int'(busy), 0);
    @(posedge clk); #1;
    check_eq("zero_mask_busy2", int'(busy), 0);

    run_scan(4'b0011, NCH'($urandom), NCH'($urandom), 0, '0, '0, P + 2 + int'(SETTLE) + 2, 1'b0);

    reset_mid_scan();
    run_scan(4'b0100, NCH'($urandom), NCH'($urandom), 0, '0, '0, 0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      gap = 0;
      if ($urandom_range(0, 1) == 1) gap = $urandom_range(1, $countones(m) * P - 1);
      run_scan(m, NCH'($urandom), NCH'($urandom), 0, '0, '0, gap,
               1'($urandom_range(0, 1)));
      idle_hold(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
